multicycle_control: RTL and testbench

Main control FSM for the multicycle MIPS datapath. It steps each instruction through fetch, decode, execute, memory and writeback states and drives every datapath enable and mux select. Its `aluop` output feeds `Alu_control`, which resolves `select` from `funct`. It sits between instruction-register opcode decode and the shared ALU, register file, PC and unified memory.

---
 rtl/multicycle_control.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: steps each instruction
// through fetch/decode/execute/memory/writeback and drives all datapath controls.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE   = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_ADDI_EX   = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [3:0] out_state;

  // Raw enables before the reset mask
  logic pc_write_raw;
  logic pc_write_cond_raw;
  logic mem_read_raw;
  logic mem_write_raw;
  logic ir_write_raw;
  logic reg_write_raw;
  logic instr_done_raw;
  logic illegal_op_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_ADDI_EX:   state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  // During reset the selects present FETCH values regardless of the held state
  assign out_state = rst ? S_FETCH : state_q;

  always_comb begin
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    mem_read_raw      = 1'b0;
    mem_write_raw     = 1'b0;
    ir_write_raw      = 1'b0;
    reg_write_raw     = 1'b0;
    instr_done_raw    = 1'b0;
    illegal_op_raw    = 1'b0;
    iord              = 1'b0;
    mem_to_reg        = 1'b0;
    reg_dst           = 1'b0;
    alu_src_a         = 1'b0;
    alu_src_b         = SRCB_B;
    aluop             = ALUOP_ADD;
    pc_source         = PCSRC_ALU;
    case (out_state)
      S_FETCH: begin
        mem_read_raw = 1'b1;
        alu_src_b    = SRCB_FOUR;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
      end
      S_DECODE: begin
        alu_src_b      = SRCB_IMMSH;
        illegal_op_raw = ~is_supported(opcode);
        instr_done_raw = ~is_supported(opcode);
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        mem_read_raw = 1'b1;
        iord         = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_raw  = 1'b1;
        mem_to_reg     = 1'b1;
        instr_done_raw = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write_raw  = 1'b1;
        iord           = 1'b1;
        instr_done_raw = mem_ready;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_FUNCT;
      end
      S_R_WB: begin
        reg_write_raw  = 1'b1;
        reg_dst        = 1'b1;
        instr_done_raw = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a         = 1'b1;
        aluop             = ALUOP_SUB;
        pc_write_cond_raw = 1'b1;
        pc_source         = PCSRC_ALUOUT;
        instr_done_raw    = 1'b1;
      end
      S_JUMP: begin
        pc_write_raw   = 1'b1;
        pc_source      = PCSRC_JUMP;
        instr_done_raw = 1'b1;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: begin
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign pc_write      = pc_write_raw      & ~rst;
  assign pc_write_cond = pc_write_cond_raw & ~rst;
  assign mem_read      = mem_read_raw      & ~rst;
  assign mem_write     = mem_write_raw     & ~rst;
  assign ir_write      = ir_write_raw      & ~rst;
  assign reg_write     = reg_write_raw     & ~rst;
  assign instr_done    = instr_done_raw    & ~rst;
  assign illegal_op    = illegal_op_raw    & ~rst;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes the expected output
// vector per cycle, a monitor pops and compares it on the falling edge.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, aluop, pc_source;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct {
    logic [21:0] exp;
    string       name;
  } sb_item_t;

  sb_item_t sb[$];
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  // Vector layout: state, pc_write, pc_write_cond, iord, mem_read, mem_write,
  // ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, aluop,
  // pc_source, instr_done, illegal_op
  function automatic logic [21:0] mk(input logic [3:0] st,
      input logic pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa,
      input logic [1:0] asb, aop, ps, input logic dn, il);
    return {st, pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps, dn, il};
  endfunction

  function automatic logic [21:0] e_rst(input logic [3:0] st);
    return mk(st, 0,0,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
  endfunction

  logic [21:0] E_FW, E_FG, E_DEC, E_DILL, E_MA, E_MR, E_MWB, E_MWW, E_MWG;
  logic [21:0] E_EX, E_RWB, E_BR, E_J, E_AEX, E_AWB;

  task automatic cyc(input logic r, input logic [5:0] op, input logic rdy,
                     input string name, input logic [21:0] exp);
    sb_item_t it;
    rst       = r;
    opcode    = op;
    mem_ready = rdy;
    it.exp    = exp;
    it.name   = name;
    sb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are presented every cycle, checked mid-cycle
  initial begin
    sb_item_t it;
    logic [21:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        it  = sb.pop_front();
        act = {state, pc_write, pc_write_cond, iord, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               aluop, pc_source, instr_done, illegal_op};
        checks++;
        if (act === it.exp) passed++;
        else $display("FAIL %s: got %b expected %b", it.name, act, it.exp);
      end
    end
  end

  initial begin
    E_FW   = mk(4'd0,  0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
    E_FG   = mk(4'd0,  1,0,0,1,0,1,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
    E_DEC  = mk(4'd1,  0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0,0);
    E_DILL = mk(4'd1,  0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 1,1);
    E_MA   = mk(4'd2,  0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0);
    E_MR   = mk(4'd3,  0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
    E_MWB  = mk(4'd4,  0,0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 1,0);
    E_MWW  = mk(4'd5,  0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
    E_MWG  = mk(4'd5,  0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 1,0);
    E_EX   = mk(4'd6,  0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 0,0);
    E_RWB  = mk(4'd7,  0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00, 1,0);
    E_BR   = mk(4'd8,  0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 1,0);
    E_J    = mk(4'd9,  1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 1,0);
    E_AEX  = mk(4'd10, 0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0);
    E_AWB  = mk(4'd11, 0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 1,0);

    rst = 1'b1; opcode = OP_R; mem_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset then R-type
    cyc(1, OP_R, 1, "reset_c1", e_rst(4'd0));
    cyc(1, OP_R, 1, "reset_c2", e_rst(4'd0));
    cyc(0, OP_R, 1, "r_fetch",   E_FG);
    cyc(0, OP_R, 1, "r_decode",  E_DEC);
    cyc(0, OP_R, 1, "r_execute", E_EX);
    cyc(0, OP_R, 1, "r_wb",      E_RWB);

    // lw with two wait states in MEM_READ
    cyc(0, OP_LW, 1, "lw_fetch",   E_FG);
    cyc(0, OP_LW, 1, "lw_decode",  E_DEC);
    cyc(0, OP_LW, 1, "lw_memaddr", E_MA);
    cyc(0, OP_LW, 0, "lw_rd_w1",   E_MR);
    cyc(0, OP_LW, 0, "lw_rd_w2",   E_MR);
    cyc(0, OP_LW, 1, "lw_rd_go",   E_MR);
    cyc(0, OP_LW, 1, "lw_wb",      E_MWB);

    // sw, beq, j back to back
    cyc(0, OP_SW, 1, "sw_fetch",   E_FG);
    cyc(0, OP_SW, 1, "sw_decode",  E_DEC);
    cyc(0, OP_SW, 1, "sw_memaddr", E_MA);
    cyc(0, OP_SW, 1, "sw_write",   E_MWG);
    cyc(0, OP_BEQ, 1, "beq_fetch",  E_FG);
    cyc(0, OP_BEQ, 1, "beq_decode", E_DEC);
    cyc(0, OP_BEQ, 1, "beq_branch", E_BR);
    cyc(0, OP_J, 1, "j_fetch",  E_FG);
    cyc(0, OP_J, 1, "j_decode", E_DEC);
    cyc(0, OP_J, 1, "j_jump",   E_J);

    // FETCH wait, then addi
    cyc(0, OP_ADDI, 0, "fetch_w1",   E_FW);
    cyc(0, OP_ADDI, 0, "fetch_w2",   E_FW);
    cyc(0, OP_ADDI, 0, "fetch_w3",   E_FW);
    cyc(0, OP_ADDI, 1, "fetch_go",   E_FG);
    cyc(0, OP_ADDI, 1, "addi_decode", E_DEC);
    cyc(0, OP_ADDI, 1, "addi_ex",    E_AEX);
    cyc(0, OP_ADDI, 1, "addi_wb",    E_AWB);

    // Illegal opcode
    cyc(0, OP_BAD, 1, "ill_fetch",  E_FG);
    cyc(0, OP_BAD, 1, "ill_decode", E_DILL);
    cyc(0, OP_BAD, 0, "ill_back_fetch", E_FW);

    // Reset asserted during a MEM_WRITE wait
    cyc(0, OP_SW, 1, "sw2_fetch",   E_FG);
    cyc(0, OP_SW, 1, "sw2_decode",  E_DEC);
    cyc(0, OP_SW, 1, "sw2_memaddr", E_MA);
    cyc(0, OP_SW, 0, "sw2_wait",    E_MWW);
    cyc(1, OP_SW, 0, "sw2_rst_in_write", e_rst(4'd5));
    cyc(1, OP_SW, 1, "sw2_rst_hold",     e_rst(4'd0));
    cyc(0, OP_SW, 0, "post_rst_fetch",   E_FW);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
